// File: rtl/iqft_2_qubit_seq_pkg.sv
// Shared fixed-point (S_3.4) constants and FSM encoding for the sequential 2-qubit inverse QFT.
package iqft_2_qubit_seq_pkg;

  localparam int TOTAL_BITS = 8;
  localparam int FX_BITS    = 4;
  localparam int AMP_W      = TOTAL_BITS * 2;
  localparam int VEC_W      = AMP_W * 4;

  localparam logic signed [TOTAL_BITS-1:0] ONE_OVER_SQRT2 = 8'sd11;
  localparam logic signed [TOTAL_BITS-1:0] FX_MAX         = 8'sd127;
  localparam logic signed [TOTAL_BITS-1:0] FX_MIN         = -8'sd128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PERM = 3'd1,
    H0   = 3'd2,
    H1   = 3'd3,
    DONE = 3'd4
  } iqft_state_t;

endpackage

// File: rtl/iqft_2_qubit_seq_butterfly.sv
// Combinational Hadamard butterfly on two complex S_3.4 amps: (a+b)/sqrt2, (a-b)/sqrt2.
// Optional IQFT_SAT_EN: saturate sum/difference and scaled result instead of wrapping.
module iqft_butterfly
  import iqft_2_qubit_seq_pkg::*;
(
  input  logic [AMP_W-1:0] amp_a,
  input  logic [AMP_W-1:0] amp_b,
  output logic [AMP_W-1:0] sum_s,
  output logic [AMP_W-1:0] diff_s
);

  function automatic logic signed [TOTAL_BITS-1:0] addsub_fx(
    input logic signed [TOTAL_BITS-1:0] x,
    input logic signed [TOTAL_BITS-1:0] y,
    input logic                         sub
  );
    logic signed [TOTAL_BITS:0] xe;
    logic signed [TOTAL_BITS:0] ye;
    logic signed [TOTAL_BITS:0] r;
    xe = x;
    ye = y;
    r  = sub ? (xe - ye) : (xe + ye);
`ifdef IQFT_SAT_EN
    if (r > 9'sd127)
      return FX_MAX;
    else if (r < -9'sd128)
      return FX_MIN;
    else
      return r[TOTAL_BITS-1:0];
`else
    return r[TOTAL_BITS-1:0];
`endif
  endfunction

  // Product at double width, floor shift, then wrap (or clamp) back to TOTAL_BITS.
  function automatic logic signed [TOTAL_BITS-1:0] scale_fx(
    input logic signed [TOTAL_BITS-1:0] x
  );
    logic signed [2*TOTAL_BITS-1:0] xe;
    logic signed [2*TOTAL_BITS-1:0] ce;
    logic signed [2*TOTAL_BITS-1:0] p;
    logic signed [2*TOTAL_BITS-1:0] sh;
    xe = x;
    ce = ONE_OVER_SQRT2;
    p  = xe * ce;
    sh = p >>> FX_BITS;
`ifdef IQFT_SAT_EN
    if (sh > 16'sd127)
      return FX_MAX;
    else if (sh < -16'sd128)
      return FX_MIN;
    else
      return sh[TOTAL_BITS-1:0];
`else
    return sh[TOTAL_BITS-1:0];
`endif
  endfunction

  logic signed [TOTAL_BITS-1:0] a_re, a_im, b_re, b_im;

  always_comb begin
    a_re   = amp_a[AMP_W-1:TOTAL_BITS];
    a_im   = amp_a[TOTAL_BITS-1:0];
    b_re   = amp_b[AMP_W-1:TOTAL_BITS];
    b_im   = amp_b[TOTAL_BITS-1:0];
    sum_s  = {scale_fx(addsub_fx(a_re, b_re, 1'b0)), scale_fx(addsub_fx(a_im, b_im, 1'b0))};
    diff_s = {scale_fx(addsub_fx(a_re, b_re, 1'b1)), scale_fx(addsub_fx(a_im, b_im, 1'b1))};
  end

endmodule

// File: rtl/iqft_2_qubit_seq.sv
// Sequential 2-qubit inverse QFT: SWAP -> CPHASE(-pi/2) -> H on Q0, one shared butterfly.
// Optional IQFT_SAT_EN: saturating arithmetic (including -(-128) -> +127 in the phase step).
module iqft_2_qubit_seq
  import iqft_2_qubit_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] q_state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] q_state_out,
  output logic             busy
);

  function automatic logic signed [TOTAL_BITS-1:0] neg_fx(
    input logic signed [TOTAL_BITS-1:0] x
  );
`ifdef IQFT_SAT_EN
    return (x == FX_MIN) ? FX_MAX : -x;
`else
    return -x;
`endif
  endfunction

  iqft_state_t state, state_nxt;

  logic [AMP_W-1:0] a00, a01, a10, a11;
  logic [AMP_W-1:0] bf_a, bf_b, bf_sum, bf_diff;
  logic [VEC_W-1:0] q_out_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          state_nxt = PERM;
      end
      PERM:    state_nxt = H0;
      H0:      state_nxt = H1;
      H1:      state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The single butterfly serves (a00,a10) in H0 and (a01,a11) in H1.
  always_comb begin
    bf_a = (state == H0) ? a00 : a01;
    bf_b = (state == H0) ? a10 : a11;
  end

  iqft_butterfly u_bf (
    .amp_a  (bf_a),
    .amp_b  (bf_b),
    .sum_s  (bf_sum),
    .diff_s (bf_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a00     <= '0;
      a01     <= '0;
      a10     <= '0;
      a11     <= '0;
      q_out_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a00 <= q_state_in[4*AMP_W-1:3*AMP_W];
            a01 <= q_state_in[3*AMP_W-1:2*AMP_W];
            a10 <= q_state_in[2*AMP_W-1:AMP_W];
            a11 <= q_state_in[AMP_W-1:0];
          end
        end
        PERM: begin
          // Multiply by -i: (re, im) -> (im, -re).
          a01 <= a10;
          a10 <= a01;
          a11 <= {a11[TOTAL_BITS-1:0], neg_fx(a11[AMP_W-1:TOTAL_BITS])};
        end
        H0: begin
          a00 <= bf_sum;
          a10 <= bf_diff;
        end
        H1: begin
          a01     <= bf_sum;
          a11     <= bf_diff;
          q_out_r <= {a00, bf_sum, a10, bf_diff};
        end
        default: ;
      endcase
    end
  end

  assign q_state_out = q_out_r;

endmodule

// File: tb/tb_iqft_2_qubit_seq.sv
// Directed self-checking bench for iqft_2_qubit_seq (expectations follow IQFT_SAT_EN if defined).
module tb_iqft_2_qubit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] q_state_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] q_state_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iqft_2_qubit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q_state_in  (q_state_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q_state_out (q_state_out),
    .busy        (busy)
  );

  function automatic logic [15:0] amp(input int re, input int im);
    logic [7:0] r;
    logic [7:0] i;
    r = 8'(re);
    i = 8'(im);
    return {r, i};
  endfunction

  // Offer v, wait (bounded) for out_valid, capture the result, then hand it off.
  task automatic xfer(input logic [63:0] v, output logic [63:0] res, output int lat, output bit ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    in_valid   = 1'b1;
    q_state_in = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    ok  = out_valid;
    res = q_state_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (q_state_out !== 64'h0) begin errors++; $display("FAIL reset_q_out got=%h exp=0", q_state_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [63:0] vin [6];
    logic [63:0] vexp [6];
    logic [63:0] res;
    int lat;
    bit ok;
    vin[0]  = {amp(16, 0), amp(0, 0), amp(0, 0), amp(0, 0)};
    vexp[0] = {amp(11, 0), amp(0, 0), amp(11, 0), amp(0, 0)};
    vin[1]  = {amp(0, 0), amp(0, 0), amp(0, 0), amp(16, 0)};
    vexp[1] = {amp(0, 0), amp(0, -11), amp(0, 0), amp(0, 11)};
    vin[2]  = {amp(0, 0), amp(16, 0), amp(0, 0), amp(0, 0)};
    vexp[2] = {amp(11, 0), amp(0, 0), amp(-11, 0), amp(0, 0)};
    // Both 127s meet in the H0 pair after the swap.
    vin[3]  = {amp(127, 0), amp(127, 0), amp(0, 0), amp(0, 0)};
    vin[4]  = {amp(0, 0), amp(0, 0), amp(0, 0), amp(-128, 0)};
    vin[5]  = {amp(32, -16), amp(16, 8), amp(0, 0), amp(0, 0)};
    vexp[5] = {amp(33, -6), amp(0, 0), amp(11, -17), amp(0, 0)};
`ifdef IQFT_SAT_EN
    vexp[3] = {amp(87, 0), amp(0, 0), amp(0, 0), amp(0, 0)};
    vexp[4] = {amp(0, 0), amp(0, 87), amp(0, 0), amp(0, -88)};
`else
    vexp[3] = {amp(-2, 0), amp(0, 0), amp(0, 0), amp(0, 0)};
    vexp[4] = {amp(0, 0), amp(0, -88), amp(0, 0), amp(0, -88)};
`endif
    for (int i = 0; i < 6; i++) begin
      xfer(vin[i], res, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL vec%0d_out_valid got=0 exp=1 within 8 cycles", i); end
      checks++; if (lat > 4) begin errors++; $display("FAIL vec%0d_latency got=%0d exp<=4", i, lat); end
      checks++; if (res !== vexp[i]) begin errors++; $display("FAIL vec%0d_result got=%h exp=%h", i, res, vexp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] held;
    logic [63:0] v1, e1, v2, e2;
    int guard;
    v1 = {amp(16, 0), amp(0, 0), amp(0, 0), amp(0, 0)};
    e1 = {amp(11, 0), amp(0, 0), amp(11, 0), amp(0, 0)};
    v2 = {amp(0, 0), amp(0, 0), amp(0, 0), amp(16, 0)};
    e2 = {amp(0, 0), amp(0, -11), amp(0, 0), amp(0, 11)};
    in_valid = 1'b1; q_state_in = v1;
    @(posedge clk); #1;
    q_state_in = v2;
    guard = 0;
    while (!out_valid && guard < 8) begin @(posedge clk); #1; guard++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_first_valid got=%b exp=1", out_valid); end
    checks++; if (q_state_out !== e1) begin errors++; $display("FAIL hold_first_result got=%h exp=%h", q_state_out, e1); end
    held = q_state_out;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (q_state_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got q=%h v=%b rdy=%b exp q=%h v=1 rdy=0", c, q_state_out, out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handoff got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL second_accept busy got=%b exp=1", busy); end
    guard = 0;
    while (!out_valid && guard < 8) begin @(posedge clk); #1; guard++; end
    checks++; if (q_state_out !== e2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL second_result got=%h v=%b exp=%h v=1", q_state_out, out_valid, e2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0] res, e3;
    int lat;
    bit ok;
    e3 = {amp(11, 0), amp(0, 0), amp(-11, 0), amp(0, 0)};
    in_valid = 1'b1; q_state_in = {amp(16, 0), amp(0, 0), amp(0, 0), amp(0, 0)};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl got v=%b rdy=%b busy=%b exp v=0 rdy=1 busy=0", out_valid, in_ready, busy);
    end
    checks++; if (q_state_out !== 64'h0) begin errors++; $display("FAIL midreset_q_out got=%h exp=0", q_state_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_residue out_valid got=1 exp=0"); end
    end
    xfer({amp(0, 0), amp(16, 0), amp(0, 0), amp(0, 0)}, res, lat, ok);
    checks++; if (!ok || res !== e3) begin
      errors++; $display("FAIL midreset_fresh got=%h v=%b exp=%h v=1", res, ok, e3);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
